// File: rtl/pc_seq_pkg.sv
// Shared types and defaults for the program-counter sequencer.
// Optional branch delay slot is selected with PC_SEQ_DELAY_SLOT_EN.
package pc_seq_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        FETCH = 2'd1,
        EXEC  = 2'd2,
        HALT  = 2'd3
    } state_t;

    localparam logic [31:0] DEF_RESET_PC    = 32'h0000_0000;
    localparam int          DEF_INSTR_BYTES = 4;

    // Redirect targets are always loaded word-aligned.
    function automatic logic [31:0] word_align(input logic [31:0] addr);
        return {addr[31:2], 2'b00};
    endfunction

endpackage

// File: rtl/pcmais4.sv
// Sequential next-PC incrementer; wraps modulo 2^32 with no carry out.
module pcmais4 #(
    parameter int INSTR_BYTES = 4
) (
    input  logic [31:0] pc,
    output logic [31:0] pc_plus4
);

    assign pc_plus4 = pc + 32'(INSTR_BYTES);

endmodule

// File: rtl/pc_sequencer.sv
// Program counter owner: fetches over a req/ack handshake, waits for execute,
// then steps or redirects the PC. PC_SEQ_DELAY_SLOT_EN enables the MIPS delay slot.
module pc_sequencer
    import pc_seq_pkg::*;
#(
    parameter logic [31:0] RESET_PC    = DEF_RESET_PC,
    parameter int          INSTR_BYTES = DEF_INSTR_BYTES
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        start,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_ack,
    input  logic [31:0] instr_in,
    output logic [31:0] instr_out,
    output logic        instr_valid,
    input  logic        exec_done,
    input  logic        branch_taken,
    input  logic [31:0] branch_target,
    input  logic        jump,
    input  logic [31:0] jump_target,
    input  logic        halt,
    output logic [31:0] pc,
    output logic [31:0] pc_plus4,
    output logic        misalign,
    output logic        busy
);

    state_t      state;
    logic        redirect;
    logic [31:0] redirect_target;

    pcmais4 #(
        .INSTR_BYTES(INSTR_BYTES)
    ) u_pcmais4 (
        .pc      (pc),
        .pc_plus4(pc_plus4)
    );

    assign imem_addr = pc;
    assign busy      = (state == FETCH) || (state == EXEC);

    // Jump outranks a simultaneously taken branch.
    always_comb begin
        redirect        = jump | branch_taken;
        redirect_target = jump ? jump_target : branch_target;
    end

`ifdef PC_SEQ_DELAY_SLOT_EN
    logic        pending;
    logic [31:0] pending_target;
`endif

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state       <= IDLE;
            pc          <= RESET_PC;
            instr_out   <= '0;
            instr_valid <= 1'b0;
            imem_req    <= 1'b0;
            misalign    <= 1'b0;
`ifdef PC_SEQ_DELAY_SLOT_EN
            pending        <= 1'b0;
            pending_target <= '0;
`endif
        end else begin
            instr_valid <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        state    <= FETCH;
                        imem_req <= 1'b1;
                    end
                end
                FETCH: begin
                    if (imem_ack) begin
                        instr_out   <= instr_in;
                        instr_valid <= 1'b1;
                        imem_req    <= 1'b0;
                        state       <= EXEC;
                    end
                end
                EXEC: begin
                    if (exec_done) begin
                        if (halt) begin
                            state <= HALT;
`ifdef PC_SEQ_DELAY_SLOT_EN
                            pending <= 1'b0;
`endif
                        end else begin
                            state    <= FETCH;
                            imem_req <= 1'b1;
`ifdef PC_SEQ_DELAY_SLOT_EN
                            // The delay-slot instruction's own redirect is dropped.
                            if (pending) begin
                                pc      <= pending_target;
                                pending <= 1'b0;
                            end else if (redirect) begin
                                pending        <= 1'b1;
                                pending_target <= word_align(redirect_target);
                                misalign       <= misalign | (|redirect_target[1:0]);
                                pc             <= pc_plus4;
                            end else begin
                                pc <= pc_plus4;
                            end
`else
                            if (redirect) begin
                                pc       <= word_align(redirect_target);
                                misalign <= misalign | (|redirect_target[1:0]);
                            end else begin
                                pc <= pc_plus4;
                            end
`endif
                        end
                    end
                end
                HALT: begin
                    state <= HALT;
                end
                default: begin
                    state    <= IDLE;
                    imem_req <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_pc_sequencer.sv
// Directed self-checking bench for pc_sequencer (default build; delay-slot
// vectors are compiled in when PC_SEQ_DELAY_SLOT_EN is defined).
module tb_pc_sequencer;

    logic        clock = 1'b0;
    logic        reset;
    logic        start;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ack;
    logic [31:0] instr_in;
    logic [31:0] instr_out;
    logic        instr_valid;
    logic        exec_done;
    logic        branch_taken;
    logic [31:0] branch_target;
    logic        jump;
    logic [31:0] jump_target;
    logic        halt;
    logic [31:0] pc;
    logic [31:0] pc_plus4;
    logic        misalign;
    logic        busy;

    int tests  = 0;
    int failed = 0;

    pc_sequencer dut (
        .clock        (clock),
        .reset        (reset),
        .start        (start),
        .imem_req     (imem_req),
        .imem_addr    (imem_addr),
        .imem_ack     (imem_ack),
        .instr_in     (instr_in),
        .instr_out    (instr_out),
        .instr_valid  (instr_valid),
        .exec_done    (exec_done),
        .branch_taken (branch_taken),
        .branch_target(branch_target),
        .jump         (jump),
        .jump_target  (jump_target),
        .halt         (halt),
        .pc           (pc),
        .pc_plus4     (pc_plus4),
        .misalign     (misalign),
        .busy         (busy)
    );

    always #5 clock = ~clock;

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        tests++;
        assert (obs === expv) else begin
            failed++;
            $error("FAIL %s: observed %h expected %h", tag, obs, expv);
        end
    endtask

    task automatic chk1(input string tag, input logic obs, input logic expv);
        tests++;
        assert (obs === expv) else begin
            failed++;
            $error("FAIL %s: observed %b expected %b", tag, obs, expv);
        end
    endtask

    // Entered in FETCH; holds ack off for wait_cycles, then returns the word.
    task automatic fetch(input logic [31:0] addr, input logic [31:0] word, input int wait_cycles);
        chk1("fetch_req", imem_req, 1'b1);
        chk("fetch_addr", imem_addr, addr);
        for (int i = 0; i < wait_cycles; i++) begin
            step();
            chk1("wait_req", imem_req, 1'b1);
            chk("wait_addr", imem_addr, addr);
            chk1("wait_valid", instr_valid, 1'b0);
        end
        instr_in = word;
        imem_ack = 1'b1;
        step();
        imem_ack = 1'b0;
        instr_in = 32'hDEAD_BEEF;
        chk1("ack_valid", instr_valid, 1'b1);
        chk("ack_instr", instr_out, word);
        chk1("ack_req_low", imem_req, 1'b0);
    endtask

    // Entered in the first EXEC cycle; reports completion with the given redirects.
    task automatic execute(input logic j, input logic [31:0] jt, input logic b,
                           input logic [31:0] bt, input logic h, input logic [31:0] exp_pc);
        exec_done     = 1'b1;
        jump          = j;
        jump_target   = jt;
        branch_taken  = b;
        branch_target = bt;
        halt          = h;
        step();
        exec_done    = 1'b0;
        jump         = 1'b0;
        branch_taken = 1'b0;
        halt         = 1'b0;
        chk("exec_pc", pc, exp_pc);
        chk1("exec_valid_low", instr_valid, 1'b0);
    endtask

    initial begin
        reset = 1'b1; start = 1'b0; imem_ack = 1'b0; instr_in = '0;
        exec_done = 1'b0; branch_taken = 1'b0; branch_target = '0;
        jump = 1'b0; jump_target = '0; halt = 1'b0;
        step(); step();
        chk("rst_pc", pc, 32'h0);
        chk("rst_instr", instr_out, 32'h0);
        chk1("rst_req", imem_req, 1'b0);
        chk1("rst_valid", instr_valid, 1'b0);
        chk1("rst_misalign", misalign, 1'b0);
        chk1("rst_busy", busy, 1'b0);
        reset = 1'b0;
        step();
        chk1("idle_busy", busy, 1'b0);

        // Three sequential instructions with immediate ack.
        start = 1'b1;
        step();
        start = 1'b0;
        chk1("fetch_busy", busy, 1'b1);
        chk("pc_plus4_0", pc_plus4, 32'h4);
        fetch(32'h0, 32'hA000_0000, 0);
        execute(1'b0, '0, 1'b0, '0, 1'b0, 32'h4);
        fetch(32'h4, 32'hA000_0001, 0);
        execute(1'b0, '0, 1'b0, '0, 1'b0, 32'h8);
        fetch(32'h8, 32'hA000_0002, 0);
        execute(1'b0, '0, 1'b0, '0, 1'b0, 32'hC);

        // Slow memory, then redirects ignored without exec_done.
        fetch(32'hC, 32'hA000_0003, 5);
        jump = 1'b1; jump_target = 32'h0000_0500; halt = 1'b1;
        step();
        jump = 1'b0; halt = 1'b0;
        chk("no_done_pc", pc, 32'hC);
        chk1("no_done_busy", busy, 1'b1);
        chk1("no_done_req", imem_req, 1'b0);
        execute(1'b1, 32'h40, 1'b1, 32'h80, 1'b0, 32'h40);
        chk1("jump_misalign", misalign, 1'b0);

        fetch(32'h40, 32'hB000_0000, 1);
        execute(1'b0, '0, 1'b1, 32'h82, 1'b0, 32'h80);
        chk1("branch_misalign", misalign, 1'b1);
        fetch(32'h80, 32'hB000_0001, 0);
        execute(1'b0, '0, 1'b0, '0, 1'b0, 32'h84);
        chk1("misalign_sticky", misalign, 1'b1);

        // Wrap-around of the sequential increment.
        fetch(32'h84, 32'hB000_0002, 0);
        execute(1'b1, 32'hFFFF_FFFC, 1'b0, '0, 1'b0, 32'hFFFF_FFFC);
        chk("pc_plus4_wrap", pc_plus4, 32'h0);
        fetch(32'hFFFF_FFFC, 32'hB000_0003, 0);
        execute(1'b0, '0, 1'b0, '0, 1'b0, 32'h0);
        fetch(32'h0, 32'hB000_0004, 0);
        execute(1'b0, '0, 1'b0, '0, 1'b0, 32'h4);

        // Halt freezes everything; start has no effect.
        fetch(32'h4, 32'hC000_0000, 0);
        execute(1'b1, 32'h300, 1'b0, '0, 1'b1, 32'h4);
        chk1("halt_busy", busy, 1'b0);
        chk1("halt_req", imem_req, 1'b0);
        start = 1'b1;
        step(); step();
        start = 1'b0;
        chk("halt_pc_frozen", pc, 32'h4);
        chk1("halt_start_busy", busy, 1'b0);
        chk1("halt_start_req", imem_req, 1'b0);

        // Asynchronous reset in the middle of a fetch.
        reset = 1'b1;
        #1;
        chk1("rst2_misalign", misalign, 1'b0);
        step();
        reset = 1'b0;
        start = 1'b1;
        step();
        start = 1'b0;
        fetch(32'h0, 32'hD000_0000, 0);
        execute(1'b0, '0, 1'b0, '0, 1'b0, 32'h4);
        chk1("pre_rst_req", imem_req, 1'b1);
        #2;
        reset = 1'b1;
        #1;
        chk("async_rst_pc", pc, 32'h0);
        chk1("async_rst_req", imem_req, 1'b0);
        chk1("async_rst_busy", busy, 1'b0);
        step();
        reset = 1'b0;
        instr_in = 32'hEEEE_0000;
        imem_ack = 1'b1;
        step(); step();
        imem_ack = 1'b0;
        chk1("late_ack_valid", instr_valid, 1'b0);
        chk("late_ack_instr", instr_out, 32'h0);
        chk1("late_ack_busy", busy, 1'b0);

`ifdef PC_SEQ_DELAY_SLOT_EN
        // Branch at 0x0 to 0x10 executes the slot at 0x4 first; slot redirect dropped.
        start = 1'b1;
        step();
        start = 1'b0;
        fetch(32'h0, 32'hF000_0000, 0);
        execute(1'b0, '0, 1'b1, 32'h10, 1'b0, 32'h4);
        fetch(32'h4, 32'hF000_0001, 0);
        execute(1'b0, '0, 1'b1, 32'h300, 1'b0, 32'h10);
        fetch(32'h10, 32'hF000_0002, 0);
        execute(1'b0, '0, 1'b1, 32'h100, 1'b0, 32'h14);
        fetch(32'h14, 32'hF000_0003, 0);
        execute(1'b0, '0, 1'b1, 32'h200, 1'b0, 32'h100);
        fetch(32'h100, 32'hF000_0004, 0);
        execute(1'b0, '0, 1'b0, '0, 1'b0, 32'h104);
`endif

        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end

endmodule
